motor_plant: RTL and testbench
==============================

# motor_plant

Synthesizable actuator model that sits on the far side of the motor control interface. It consumes `motor_up`/`motor_dn` drive commands and produces the `up_limit`/`dn_limit` switch outputs. It tracks carriage position with a prescaled step counter between two end stops. It is used as the closed-loop partner of the motor controller in system simulation and FPGA demo builds.

## Interface
- `TRAVEL`, 16: position value of the top end stop; bottom end stop is 0. Must be ≥ 1.
- `STEP_DIV`, 4: clock cycles per one-position step while moving. Must be ≥ 1.
- `POS_W`, 8: width of the position counter. Must be able to hold `TRAVEL`.
- `INIT_POS`, 0: position loaded on reset, in the range 0..`TRAVEL`.
- `OVERRUN`, 2: consecutive cycles of driving into an asserted limit before a fault is raised. Used only with the fault feature. Must be ≥ 1.
- `clk` input 1: single clock; all state changes on the rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `motor_up` input 1: drive upward command.
- `motor_dn` input 1: drive downward command.
- `up_limit` output 1: high exactly when position == `TRAVEL`.
- `dn_limit` output 1: high exactly when position == 0.
- `position` output `POS_W`: current carriage position, registered.
- `moving` output 1: high when the state is `MOVE_UP` or `MOVE_DN`.
- `fault` output 1: sticky overtravel/conflict flag. Tied 0 when the fault feature is compiled out.

## Operation
- Registers: state, `position`, prescaler of width max(1, clog2(`STEP_DIV`)), and an overrun counter (fault feature only).
- `up_limit`/`dn_limit` are combinational decodes of the `position` register, so they change on the same edge as `position`.
- Reset values:
  - state = `IDLE`, `position` = `INIT_POS`, prescaler = 0, `moving` = 0, `fault` = 0.
  - Limits follow `INIT_POS`: with `INIT_POS` = 0, `dn_limit` = 1 and `up_limit` = 0.
- States: `IDLE`, `MOVE_UP`, `MOVE_DN`, and `FAULT` (fault feature only).
- `IDLE`:
  - `motor_up` & ~`motor_dn` & ~`up_limit` → `MOVE_UP`, prescaler cleared.
  - `motor_dn` & ~`motor_up` & ~`dn_limit` → `MOVE_DN`, prescaler cleared.
  - Any other input combination → stay in `IDLE`.
- `MOVE_UP`:
  - While `motor_up` & ~`motor_dn`, the prescaler increments each cycle.
  - When the prescaler == `STEP_DIV`-1, `position` increments and the prescaler clears.
  - If that step makes `position` == `TRAVEL`, go to `IDLE` on the same edge.
- `MOVE_DN`: mirror of `MOVE_UP`. `position` decrements and the move stops at 0.
- Command dropped while moving (~`motor_up` in `MOVE_UP`): → `IDLE`, prescaler cleared, `position` held. No partial step is retained.
- Both commands asserted in any move state: → `IDLE` with no step, or → `FAULT` with the feature enabled.
- Position never wraps. It saturates by construction at 0 and `TRAVEL`.
- `FAULT`: `position` frozen, `moving` = 0, `fault` = 1. Only reset exits this state.

## Timing
- E0 is the edge at which a valid command is sampled in `IDLE`. `moving` rises at E0.
- First step lands at E0+`STEP_DIV`; subsequent steps follow every `STEP_DIV` cycles while the command is held.
- With `STEP_DIV` = 1, `position` changes on every edge from E0+1.
- Full stroke 0→`TRAVEL` completes at E0+`TRAVEL`·`STEP_DIV`. `up_limit` rises and `moving` falls on that edge.
- A command held against an asserted limit is ignored in `IDLE`. The controller's one-cycle registered release is therefore legal.
- Reset asserted mid-move takes effect immediately and asynchronously. `position` returns to `INIT_POS`.

## Configuration
- `MOTOR_PLANT_FAULT_EN` defined:
  - `FAULT` state and overrun counter are built.
  - `fault` sets on the next edge when both commands are sampled high in any state.
  - `fault` also sets when `motor_up`&`up_limit` or `motor_dn`&`dn_limit` is held for `OVERRUN` consecutive cycles. The counter clears whenever that condition drops.
  - `fault` is sticky until reset.
- Undefined: no `FAULT` state and `fault` = 0. A both-asserted command is handled as described in Operation (go to or stay in `IDLE`), and pushing into a limit is ignored indefinitely.

## Test plan
- Reset with `INIT_POS`=0 → `position`=0, `dn_limit`=1, `up_limit`=0, `moving`=0, `fault`=0.
- `TRAVEL`=16, `STEP_DIV`=4, `motor_up` held from E0 → `position` increments at E0+4, E0+8, …; reaches 16 at E0+64 with `up_limit`=1 and `moving`=0. Holding `motor_up` afterwards leaves `position`=16.
- `motor_up` for 10 cycles from `position`=0, then released → `position`=2 and state `IDLE`. On re-assertion the next step lands a full 4 cycles after the new E0.
- From `position`=16, `motor_dn` held → reaches 0 at E0+64 with `dn_limit`=1. No underflow occurs on further `motor_dn`.
- Both commands high at `position`=5:
  - macro off → `position` stays 5 and `fault`=0.
  - macro on → `fault`=1 at the next edge and stays 1 after the commands drop, until `rst_n` pulses.
- `rst_n` pulled low asynchronously mid-stroke at `position`=7 → `position`=`INIT_POS` and `moving`=0 before the next clock edge.

Source files
------------

// File: rtl/motor_plant.sv
`default_nettype none
// ============================================================================
// Module   : motor_plant
// Brief    : Actuator model for the motor control interface. Turns
//            motor_up/motor_dn drive commands into a prescaled carriage
//            position between two end stops and decodes the limit switches.
//            Optional overtravel/conflict fault logic is built when the
//            macro MOTOR_PLANT_FAULT_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module motor_plant #(
    parameter int TRAVEL   = 16,
    parameter int STEP_DIV = 4,
    parameter int POS_W    = 8,
    parameter int INIT_POS = 0,
    parameter int OVERRUN  = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             motor_up,
    input  logic             motor_dn,
    output logic             up_limit,
    output logic             dn_limit,
    output logic [POS_W-1:0] position,
    output logic             moving,
    output logic             fault
);

    localparam int               PS_W    = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [PS_W-1:0]  PS_LAST = PS_W'(STEP_DIV - 1);
    localparam logic [POS_W-1:0] TOP     = POS_W'(TRAVEL);
    localparam logic [POS_W-1:0] TOP_M1  = POS_W'(TRAVEL - 1);
    localparam logic [POS_W-1:0] START   = POS_W'(INIT_POS);

    // Elaboration-time guard against parameter sets the plant cannot model.
    generate
        if (TRAVEL < 1 || STEP_DIV < 1 || OVERRUN < 1 || INIT_POS < 0 ||
            INIT_POS > TRAVEL || POS_W < 1 || POS_W > 30 ||
            TRAVEL > (2 ** POS_W) - 1) begin : g_bad_params
            $error("motor_plant: illegal parameter combination");
        end
    endgenerate

`ifdef MOTOR_PLANT_FAULT_EN
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MOVE_UP = 2'd1,
        MOVE_DN = 2'd2,
        FAULT   = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MOVE_UP = 2'd1,
        MOVE_DN = 2'd2
    } state_t;
`endif

    state_t          state;
    logic [PS_W-1:0] prescaler;

    logic cmd_up;
    logic cmd_dn;
    logic step_due;

    // A command is only valid when exactly one direction is requested.
    assign cmd_up   = motor_up & ~motor_dn;
    assign cmd_dn   = motor_dn & ~motor_up;
    assign step_due = (prescaler == PS_LAST);

    // Limit switches are pure decodes of the position register.
    assign up_limit = (position == TOP);
    assign dn_limit = (position == '0);

`ifdef MOTOR_PLANT_FAULT_EN
    localparam int              OV_W    = (OVERRUN > 1) ? $clog2(OVERRUN + 1) : 1;
    localparam logic [OV_W-1:0] OV_LAST = OV_W'(OVERRUN - 1);

    logic [OV_W-1:0] ovr_cnt;
    logic            both;
    logic            push;
    logic            fault_trip;

    assign both       = motor_up & motor_dn;
    assign push       = (motor_up & up_limit) | (motor_dn & dn_limit);
    assign fault_trip = both | (push & (ovr_cnt == OV_LAST));

    // Count consecutive cycles of pushing into an asserted limit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovr_cnt <= '0;
        end else if (!push) begin
            ovr_cnt <= '0;
        end else if (ovr_cnt != OV_LAST) begin
            ovr_cnt <= ovr_cnt + 1'b1;
        end
    end

    // Sticky fault flag; only reset clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fault <= 1'b0;
        end else if (fault_trip) begin
            fault <= 1'b1;
        end
    end
`else
    assign fault = 1'b0;
`endif

    // Carriage state machine: direction, prescaler and saturating position.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            position  <= START;
            prescaler <= '0;
            moving    <= 1'b0;
        end else begin
`ifdef MOTOR_PLANT_FAULT_EN
            if (fault_trip) begin
                state  <= FAULT;
                moving <= 1'b0;
            end else begin
`endif
            case (state)
                IDLE: begin
                    if (cmd_up && !up_limit) begin
                        state     <= MOVE_UP;
                        moving    <= 1'b1;
                        prescaler <= '0;
                    end else if (cmd_dn && !dn_limit) begin
                        state     <= MOVE_DN;
                        moving    <= 1'b1;
                        prescaler <= '0;
                    end
                end
                MOVE_UP: begin
                    if (cmd_up) begin
                        if (step_due) begin
                            position  <= position + 1'b1;
                            prescaler <= '0;
                            // Stop on the edge that lands on the top stop.
                            if (position == TOP_M1) begin
                                state  <= IDLE;
                                moving <= 1'b0;
                            end
                        end else begin
                            prescaler <= prescaler + 1'b1;
                        end
                    end else begin
                        // Released or conflicting command: drop any partial step.
                        state     <= IDLE;
                        moving    <= 1'b0;
                        prescaler <= '0;
                    end
                end
                MOVE_DN: begin
                    if (cmd_dn) begin
                        if (step_due) begin
                            position  <= position - 1'b1;
                            prescaler <= '0;
                            // Stop on the edge that lands on the bottom stop.
                            if (position == POS_W'(1)) begin
                                state  <= IDLE;
                                moving <= 1'b0;
                            end
                        end else begin
                            prescaler <= prescaler + 1'b1;
                        end
                    end else begin
                        state     <= IDLE;
                        moving    <= 1'b0;
                        prescaler <= '0;
                    end
                end
`ifdef MOTOR_PLANT_FAULT_EN
                FAULT: begin
                    moving <= 1'b0;
                end
`endif
                default: begin
                    state     <= IDLE;
                    moving    <= 1'b0;
                    prescaler <= '0;
                end
            endcase
`ifdef MOTOR_PLANT_FAULT_EN
            end
`endif
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_motor_plant.sv
`default_nettype none
// ============================================================================
// Module   : tb_motor_plant
// Brief    : Self-checking bench for motor_plant: directed table of command
//            runs, hand-written reset/overrun sequences, and a randomized run
//            against a cycle-level behavioural model of the carriage.
// Revision : 1.0 - initial release
// ============================================================================
module tb_motor_plant;

    localparam int TRAVEL   = 16;
    localparam int STEP_DIV = 4;
    localparam int POS_W    = 8;
    localparam int INIT_POS = 0;
    localparam int OVERRUN  = 2;
`ifdef MOTOR_PLANT_FAULT_EN
    localparam bit FEN = 1'b1;
`else
    localparam bit FEN = 1'b0;
`endif

    logic             clk      = 1'b0;
    logic             rst_n    = 1'b0;
    logic             motor_up = 1'b0;
    logic             motor_dn = 1'b0;
    logic             up_limit;
    logic             dn_limit;
    logic [POS_W-1:0] position;
    logic             moving;
    logic             fault;

    int vectors     = 0;
    int miscompares = 0;

    motor_plant #(
        .TRAVEL  (TRAVEL),
        .STEP_DIV(STEP_DIV),
        .POS_W   (POS_W),
        .INIT_POS(INIT_POS),
        .OVERRUN (OVERRUN)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .motor_up(motor_up),
        .motor_dn(motor_dn),
        .up_limit(up_limit),
        .dn_limit(dn_limit),
        .position(position),
        .moving  (moving),
        .fault   (fault)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Behavioural model: position as an integer, a move remembered as a
    // direction plus the number of cycles it has been held.
    // ------------------------------------------------------------------
    int m_pos;
    int m_held;
    int m_push;
    bit m_act;
    bit m_dir_up;
    bit m_fault;

    task automatic model_reset();
        m_pos   = INIT_POS;
        m_held  = 0;
        m_push  = 0;
        m_act   = 1'b0;
        m_dir_up = 1'b0;
        m_fault = 1'b0;
    endtask

    task automatic model_edge(input bit up, input bit dn);
        bit push;
        if (m_fault) return;
        push   = (up && m_pos == TRAVEL) || (dn && m_pos == 0);
        m_push = push ? m_push + 1 : 0;
        if (FEN && ((up && dn) || m_push >= OVERRUN)) begin
            m_fault = 1'b1;
            m_act   = 1'b0;
            return;
        end
        if (m_act) begin
            if (m_dir_up ? (up && !dn) : (dn && !up)) begin
                m_held++;
                if (m_held % STEP_DIV == 0) begin
                    m_pos = m_dir_up ? m_pos + 1 : m_pos - 1;
                    if (m_pos == TRAVEL || m_pos == 0) m_act = 1'b0;
                end
            end else begin
                m_act = 1'b0;
            end
        end else if (up && !dn && m_pos < TRAVEL) begin
            m_act = 1'b1; m_dir_up = 1'b1; m_held = 0;
        end else if (dn && !up && m_pos > 0) begin
            m_act = 1'b1; m_dir_up = 1'b0; m_held = 0;
        end
    endtask

    function automatic logic [31:0] pack_exp(input bit f, input bit mv, input int p);
        logic [7:0] pb;
        pb = 8'(p);
        return {20'd0, f, mv, (p == TRAVEL), (p == 0), pb};
    endfunction

    function automatic logic [31:0] pack_dut();
        return {20'd0, fault, moving, up_limit, dn_limit, position};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got {flt,mov,upl,dnl,pos}=%03h, expected %03h",
                     name, act[11:0], exp[11:0]);
        end
    endtask

    // Drive one cycle: inputs set at the falling edge, sampled at the rising.
    task automatic cycle(input bit up, input bit dn);
        motor_up = up;
        motor_dn = dn;
        @(posedge clk);
        model_edge(up, dn);
        @(negedge clk);
    endtask

    task automatic do_reset();
        motor_up = 1'b0;
        motor_dn = 1'b0;
        rst_n    = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    typedef struct {
        bit up;
        bit dn;
        int cycles;
        int pos;
        bit mov;
        bit flt;
    } vec_t;

    vec_t tbl[14];

    initial begin
        // Directed runs from reset, each row continuing from the previous.
        tbl[0]  = '{1'b1, 1'b0, 10, 2,  1'b1, 1'b0};
        tbl[1]  = '{1'b0, 1'b0, 1,  2,  1'b0, 1'b0};
        tbl[2]  = '{1'b1, 1'b0, 4,  2,  1'b1, 1'b0};
        tbl[3]  = '{1'b1, 1'b0, 1,  3,  1'b1, 1'b0};
        tbl[4]  = '{1'b1, 1'b0, 52, 16, 1'b0, 1'b0};
        tbl[5]  = '{1'b1, 1'b0, 1,  16, 1'b0, 1'b0};
        tbl[6]  = '{1'b0, 1'b0, 1,  16, 1'b0, 1'b0};
        tbl[7]  = '{1'b0, 1'b1, 65, 0,  1'b0, 1'b0};
        tbl[8]  = '{1'b0, 1'b1, 1,  0,  1'b0, 1'b0};
        tbl[9]  = '{1'b0, 1'b0, 1,  0,  1'b0, 1'b0};
        tbl[10] = '{1'b1, 1'b0, 21, 5,  1'b1, 1'b0};
        tbl[11] = '{1'b0, 1'b0, 1,  5,  1'b0, 1'b0};
        tbl[12] = '{1'b1, 1'b1, 1,  5,  1'b0, FEN};
        tbl[13] = '{1'b0, 1'b0, 3,  5,  1'b0, FEN};

        // Reset state.
        model_reset();
        @(negedge clk);
        check("reset", pack_dut(), pack_exp(1'b0, 1'b0, 0));
        rst_n = 1'b1;

        for (int i = 0; i < 14; i++) begin
            for (int c = 0; c < tbl[i].cycles; c++) cycle(tbl[i].up, tbl[i].dn);
            check($sformatf("row%0d", i), pack_dut(),
                  pack_exp(tbl[i].flt, tbl[i].mov, tbl[i].pos));
        end

        // Asynchronous reset mid-stroke at position 7.
        do_reset();
        for (int c = 0; c < 29; c++) cycle(1'b1, 1'b0);
        check("pre_async_rst", pack_dut(), pack_exp(1'b0, 1'b1, 7));
        #2 rst_n = 1'b0;
        #1 check("async_rst", pack_dut(), pack_exp(1'b0, 1'b0, INIT_POS));
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();

        // Pushing into the bottom stop: one cycle is tolerated, OVERRUN trips.
        cycle(1'b0, 1'b1);
        check("push1", pack_dut(), pack_exp(1'b0, 1'b0, 0));
        cycle(1'b0, 1'b1);
        check("push2", pack_dut(), pack_exp(FEN, 1'b0, 0));
        cycle(1'b0, 1'b0);
        cycle(1'b1, 1'b0);
        check("push_sticky", pack_dut(), pack_exp(FEN, ~FEN, 0));

        // Held up command at the top stop never overflows the position.
        do_reset();
        for (int c = 0; c < 70; c++) cycle(1'b1, 1'b0);
        check("hold_top", pack_dut(), pack_exp(FEN, 1'b0, 16));

        // Randomized command runs checked every cycle against the model.
        do_reset();
        for (int s = 0; s < 250; s++) begin
            int r;
            int len;
            bit up;
            bit dn;
            r   = $urandom_range(0, 99);
            len = $urandom_range(1, 40);
            up  = (r < 40) || (r >= 96);
            dn  = (r >= 40 && r < 80) || (r >= 96);
            if ($urandom_range(0, 99) < (m_fault ? 30 : 3)) begin
                do_reset();
                check("rand_rst", pack_dut(), pack_exp(1'b0, 1'b0, INIT_POS));
            end
            for (int c = 0; c < len; c++) begin
                cycle(up, dn);
                check("rand", pack_dut(), pack_exp(m_fault, m_act, m_pos));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
